// File: rtl/led_pattern_sequencer_if.sv
// Control/status bundle between a pattern-sequencer client and the sequencer.
// The master drives the pattern controls; the slave returns the LED state.
interface led_pattern_sequencer_if;
    logic       run;
    logic       auto;
    logic [2:0] mode_sel;
    logic       mode_load;
    logic [7:0] Q;
    logic [2:0] mode;
    logic       step_tick;

    modport master (
        output run,
        output auto,
        output mode_sel,
        output mode_load,
        input  Q,
        input  mode,
        input  step_tick
    );

    modport slave (
        input  run,
        input  auto,
        input  mode_sel,
        input  mode_load,
        output Q,
        output mode,
        output step_tick
    );
endinterface

// File: rtl/led_pattern_sequencer.sv
// 8-LED pattern sequencer: step-rate prescaler plus IDLE/SEED/RUN/HOLD FSM
// driving five shift patterns, with optional auto-advance between patterns.
module led_pattern_sequencer #(
    parameter int DIV_MAX        = 25_000_000,
    parameter int STEPS_PER_MODE = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    led_pattern_sequencer_if.slave   bus
);

    localparam int CW = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
    localparam int SW = (STEPS_PER_MODE > 2) ? $clog2(STEPS_PER_MODE) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV_MAX - 1);
    localparam logic [SW-1:0] SCNT_LAST = SW'(STEPS_PER_MODE - 1);
    localparam logic          DIR_RIGHT = 1'b0;
    localparam logic          DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    led_q, led_d;
    logic [2:0]    mode_q, mode_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic          dir_q, dir_d;
    logic          tick_q, tick_d;
    logic [8:0]    step_s;

    function automatic logic [7:0] seed_of(input logic [2:0] m);
        logic [7:0] s;
        case (m)
            3'd0:    s = 8'h80;
            3'd1:    s = 8'h01;
            3'd2:    s = 8'h80;
            3'd3:    s = 8'h81;
            3'd4:    s = 8'h00;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Returns {next_dir, next_led}; bounce reflects at the ends without repeating them.
    function automatic logic [8:0] step_of(input logic [2:0] m, input logic [7:0] q,
                                           input logic d);
        logic [8:0] r;
        case (m)
            3'd0:    r = {d, q[0], q[7:1]};
            3'd1:    r = {d, q[6:0], q[7]};
            3'd2: begin
                if (d == DIR_RIGHT) begin
                    if (q == 8'h01) begin
                        r = {DIR_LEFT, 8'h02};
                    end else begin
                        r = {d, 1'b0, q[7:1]};
                    end
                end else begin
                    if (q == 8'h80) begin
                        r = {DIR_RIGHT, 8'h40};
                    end else begin
                        r = {d, q[6:0], 1'b0};
                    end
                end
            end
            3'd3:    r = {d, q[4], q[7:5], q[2:0], q[3]};
            3'd4:    r = {d, ~q[0], q[7:1]};
            default: r = {d, q};
        endcase
        return r;
    endfunction

    assign step_s = step_of(mode_q, led_q, dir_q);

    // Next-state and datapath decode; mode_load outranks auto-advance and stepping.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        dir_d   = dir_q;
        tick_d  = 1'b0;
        if (bus.mode_load) begin
            mode_d = (bus.mode_sel > 3'd4) ? 3'd0 : bus.mode_sel;
            if (state_q == ST_IDLE) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_SEED;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    led_d = 8'h00;
                    cnt_d = '0;
                    if (bus.run) begin
                        state_d = ST_SEED;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SEED: begin
                    led_d  = seed_of(mode_q);
                    cnt_d  = '0;
                    scnt_d = '0;
                    dir_d  = DIR_RIGHT;
                    if (bus.run) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_RUN, ST_HOLD: begin
                    // HOLD resumes on the same edge run returns, so that edge still counts.
                    if (!bus.run) begin
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_RUN;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            if (bus.auto && (scnt_q == SCNT_LAST)) begin
                                mode_d  = (mode_q == 3'd4) ? 3'd0 : (mode_q + 3'd1);
                                state_d = ST_SEED;
                                scnt_d  = '0;
                            end else begin
                                {dir_d, led_d} = step_s;
                                tick_d         = 1'b1;
                                if (scnt_q == SCNT_LAST) begin
                                    scnt_d = '0;
                                end else begin
                                    scnt_d = scnt_q + SW'(1);
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    led_d   = 8'h00;
                    mode_d  = 3'd0;
                    cnt_d   = '0;
                    scnt_d  = '0;
                    dir_d   = DIR_RIGHT;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            led_q   <= 8'h00;
            mode_q  <= 3'd0;
            cnt_q   <= '0;
            scnt_q  <= '0;
            dir_q   <= DIR_RIGHT;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.Q         = led_q;
    assign bus.mode      = mode_q;
    assign bus.step_tick = tick_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer (DIV_MAX=4, STEPS_PER_MODE=8):
// pattern table plus hand-written start-up, hold, collision, auto and reset sequences.
module tb_led_pattern_sequencer;

    logic clk;
    logic reset;

    led_pattern_sequencer_if bus();

    led_pattern_sequencer #(
        .DIV_MAX       (4),
        .STEPS_PER_MODE(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [2:0] mode;
        logic       tick;
        string      name;
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        logic [2:0] exp_mode;
        int         n;
        logic [7:0] seq [0:16];
    } pat_t;

    exp_t       sb_q[$];
    pat_t       pats[0:5];
    int         n_cmp;
    int         n_err;
    logic [7:0] cur_q;

    task automatic check_vals(input logic [7:0] q, input logic [2:0] m, input logic t,
                              input string nm);
        n_cmp = n_cmp + 1;
        if (bus.Q !== q || bus.mode !== m || bus.step_tick !== t) begin
            n_err = n_err + 1;
            $display("FAIL %s: got Q=%h mode=%0d tick=%b, expected Q=%h mode=%0d tick=%b",
                     nm, bus.Q, bus.mode, bus.step_tick, q, m, t);
        end
    endtask

    // Push the expectation, let one rising edge pass, then pop and compare.
    task automatic expect_edge(input logic [7:0] q, input logic [2:0] m, input logic t,
                               input string nm);
        exp_t e;
        e.q = q; e.mode = m; e.tick = t; e.name = nm;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_vals(e.q, e.mode, e.tick, e.name);
        cur_q = e.q;
    endtask

    task automatic wait_quiet(input logic [7:0] q, input logic [2:0] m, input int n);
        for (int j = 0; j < n; j++) begin
            expect_edge(q, m, 1'b0, "between_steps");
        end
    endtask

    task automatic load_pattern(input logic [2:0] sel, input logic [2:0] m,
                                input logic [7:0] seed);
        bus.mode_sel  = sel;
        bus.mode_load = 1'b1;
        expect_edge(cur_q, m, 1'b0, "load_mode");
        bus.mode_load = 1'b0;
        expect_edge(seed, m, 1'b0, "seed_load");
    endtask

    initial begin
        pats[0] = '{3'd0, 3'd0, 9,  '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                      8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        pats[1] = '{3'd1, 3'd1, 9,  '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                      8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        pats[2] = '{3'd2, 3'd2, 16, '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                      8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h00}};
        pats[3] = '{3'd3, 3'd3, 9,  '{8'h81, 8'h42, 8'h24, 8'h18, 8'h81, 8'h42, 8'h24, 8'h18,
                                      8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        pats[4] = '{3'd4, 3'd4, 17, '{8'h00, 8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE,
                                      8'hFF, 8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00}};
        pats[5] = '{3'd6, 3'd0, 3,  '{8'h80, 8'h40, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};

        n_cmp = 0;
        n_err = 0;
        cur_q = 8'h00;
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.auto      = 1'b0;
        bus.mode_sel  = 3'd0;
        bus.mode_load = 1'b0;

        #12;
        check_vals(8'h00, 3'd0, 1'b0, "reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // mode_load while IDLE: mode follows, LEDs stay dark until run.
        bus.mode_sel  = 3'd3;
        bus.mode_load = 1'b1;
        expect_edge(8'h00, 3'd3, 1'b0, "idle_load");
        bus.mode_load = 1'b0;
        expect_edge(8'h00, 3'd3, 1'b0, "idle_stays");
        expect_edge(8'h00, 3'd3, 1'b0, "idle_stays");
        bus.run = 1'b1;
        expect_edge(8'h00, 3'd3, 1'b0, "idle_to_seed");
        expect_edge(8'h81, 3'd3, 1'b0, "seed_after_run");

        // Drop run mid-prescale (cnt=2), hold 10 cycles, resume: 2 more edges to the step.
        wait_quiet(8'h81, 3'd3, 2);
        bus.run = 1'b0;
        for (int j = 0; j < 10; j++) begin
            expect_edge(8'h81, 3'd3, 1'b0, "hold_frozen");
        end
        bus.run = 1'b1;
        expect_edge(8'h81, 3'd3, 1'b0, "resume_count");
        expect_edge(8'h42, 3'd3, 1'b1, "resume_step");
        expect_edge(8'h42, 3'd3, 1'b0, "tick_one_cycle");

        // Pattern table: load, seed, then a step every 4 edges with a tick.
        for (int i = 0; i < 6; i++) begin
            load_pattern(pats[i].sel, pats[i].exp_mode, pats[i].seq[0]);
            for (int k = 1; k < pats[i].n; k++) begin
                wait_quiet(pats[i].seq[k-1], pats[i].exp_mode, 3);
                expect_edge(pats[i].seq[k], pats[i].exp_mode, 1'b1, "pattern_step");
            end
        end

        // mode_load on the edge that would step: step is dropped, new seed next edge.
        load_pattern(3'd0, 3'd0, 8'h80);
        wait_quiet(8'h80, 3'd0, 3);
        bus.mode_sel  = 3'd1;
        bus.mode_load = 1'b1;
        expect_edge(8'h80, 3'd1, 1'b0, "load_on_step");
        bus.mode_load = 1'b0;
        expect_edge(8'h01, 3'd1, 1'b0, "seed_after_collide");
        wait_quiet(8'h01, 3'd1, 3);
        expect_edge(8'h02, 3'd1, 1'b1, "step_after_collide");

        // Auto-advance through all five patterns and back to 0.
        bus.auto = 1'b1;
        load_pattern(3'd0, 3'd0, 8'h80);
        for (int m = 0; m < 5; m++) begin
            for (int k = 1; k < 8; k++) begin
                wait_quiet(pats[m].seq[k-1], 3'(m), 3);
                expect_edge(pats[m].seq[k], 3'(m), 1'b1, "auto_step");
            end
            wait_quiet(pats[m].seq[7], 3'(m), 3);
            expect_edge(pats[m].seq[7], 3'((m + 1) % 5), 1'b0, "auto_advance");
            expect_edge(pats[(m + 1) % 5].seq[0], 3'((m + 1) % 5), 1'b0, "auto_seed");
        end
        bus.auto = 1'b0;

        // Asynchronous reset between edges while mode, Q and tick are all non-zero.
        load_pattern(3'd2, 3'd2, 8'h80);
        wait_quiet(8'h80, 3'd2, 3);
        expect_edge(8'h40, 3'd2, 1'b1, "pre_reset_step");
        #3;
        reset = 1'b1;
        #1;
        check_vals(8'h00, 3'd0, 1'b0, "async_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Start-up from reset with run already high.
        expect_edge(8'h00, 3'd0, 1'b0, "startup_seed_state");
        expect_edge(8'h80, 3'd0, 1'b0, "startup_seed");
        wait_quiet(8'h80, 3'd0, 3);
        expect_edge(8'h40, 3'd0, 1'b1, "startup_first_step");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
